sum_average_fifo: RTL and testbench

SUM_AVERAGE_FIFO -- requirements
Module: sum_average_fifo

---
 rtl/sum_average_fifo.sv | 100 ++++++++++
 tb/tb_sum_average_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_average_fifo.sv
// Frame-mean result buffer: one registered capture stage feeding a show-ahead FIFO.
// Optional macro SUM_AVERAGE_ROUND_EN selects round-half-up instead of truncation.
module sum_average_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int AVG_SHIFT  = 7
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [16:0] sum,
  input  logic        sum_enable,
  input  logic        clear,
  input  logic        avg_ready,
  output logic [7:0]  avg_data,
  output logic [3:0]  avg_frame_id,
  output logic        avg_valid,
  output logic [4:0]  fifo_count,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef SUM_AVERAGE_ROUND_EN
  localparam logic [17:0] RND = (18'd1 << AVG_SHIFT) >> 1;
`else
  localparam logic [17:0] RND = 18'd0;
`endif

  logic [17:0]   sum_ext;
  logic [17:0]   shifted;
  logic [7:0]    mean_d;

  logic [3:0]    fid_q;
  logic          s1_vld_q;
  logic [7:0]    s1_mean_q;
  logic [3:0]    s1_id_q;
  logic [11:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [4:0]    count_q;
  logic          ovf_q;

  logic          full;
  logic          pop;
  logic          wr;

  assign sum_ext = {1'b0, sum} + RND;
  assign shifted = sum_ext >> AVG_SHIFT;
  assign mean_d  = (|shifted[17:8]) ? 8'hFF : shifted[7:0];

  assign full = (count_q == 5'(FIFO_DEPTH));
  assign pop  = (count_q != 5'd0) && avg_ready;
  // A pop frees the slot on the same edge, so a full buffer still accepts.
  assign wr   = s1_vld_q && (!full || pop);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      fid_q     <= 4'h0;
      s1_vld_q  <= 1'b0;
      s1_mean_q <= 8'h00;
      s1_id_q   <= 4'h0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= 5'd0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 12'h000;
    end else if (clear) begin
      fid_q    <= 4'h0;
      s1_vld_q <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= 5'd0;
      ovf_q    <= 1'b0;
    end else begin
      s1_vld_q <= sum_enable;
      if (sum_enable) begin
        s1_mean_q <= mean_d;
        s1_id_q   <= fid_q;
        fid_q     <= fid_q + 4'h1;
      end
      if (wr) begin
        mem_q[wptr_q] <= {s1_mean_q, s1_id_q};
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (s1_vld_q && !wr) ovf_q <= 1'b1;
      case ({wr, pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign avg_data     = mem_q[rptr_q][11:4];
  assign avg_frame_id = mem_q[rptr_q][3:0];
  assign avg_valid    = (count_q != 5'd0);
  assign fifo_count   = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_sum_average_fifo.sv
// Bench for sum_average_fifo: queue-based reference plus directed literal checks.
module tb_sum_average_fifo;

  localparam int DEPTH = 4;
  localparam int SHIFT = 7;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [16:0] sum;
  logic        sum_enable;
  logic        clear;
  logic        avg_ready;
  logic [7:0]  avg_data;
  logic [3:0]  avg_frame_id;
  logic        avg_valid;
  logic [4:0]  fifo_count;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  sum_average_fifo #(.FIFO_DEPTH(DEPTH), .AVG_SHIFT(SHIFT)) dut (
    .CLK(CLK), .RST_n(RST_n), .sum(sum), .sum_enable(sum_enable), .clear(clear),
    .avg_ready(avg_ready), .avg_data(avg_data), .avg_frame_id(avg_frame_id),
    .avg_valid(avg_valid), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_mean(input int s);
    int m;
`ifdef SUM_AVERAGE_ROUND_EN
    m = (s + (1 << SHIFT) / 2) / (1 << SHIFT);
`else
    m = s / (1 << SHIFT);
`endif
    if (m > 255) m = 255;
    return m;
  endfunction

  // Reference: results enter the queue one edge after capture; drop when full with no pop.
  logic [11:0] mq[$];
  logic        m_pend;
  logic [11:0] m_pend_e;
  logic        m_ovf;
  logic [3:0]  m_fid;

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n || clear) begin
      mq.delete();
      m_pend = 1'b0;
      m_ovf  = 1'b0;
      m_fid  = 4'h0;
    end else begin
      if (mq.size() > 0 && avg_ready) mq.delete(0);
      if (m_pend) begin
        if (mq.size() < DEPTH) mq.push_back(m_pend_e);
        else m_ovf = 1'b1;
      end
      m_pend = sum_enable;
      if (sum_enable) begin
        m_pend_e = {8'(exp_mean(int'(sum))), m_fid};
        m_fid    = m_fid + 4'h1;
      end
    end
  end

  always @(negedge CLK) begin
    if (RST_n) begin
      chk("mdl_valid", 32'(avg_valid), 32'(mq.size() > 0));
      chk("mdl_count", 32'(fifo_count), 32'(mq.size()));
      chk("mdl_ovf", 32'(overflow), 32'(m_ovf));
      if (mq.size() > 0) begin
        chk("mdl_data", 32'(avg_data), 32'(mq[0][11:4]));
        chk("mdl_id", 32'(avg_frame_id), 32'(mq[0][3:0]));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic pulse(input logic [16:0] s);
    sum = s;
    sum_enable = 1'b1;
    tick();
    sum_enable = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    RST_n = 1'b0; sum = '0; sum_enable = 1'b0; clear = 1'b0; avg_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(avg_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(avg_data), 0);
    chk("rst_id", 32'(avg_frame_id), 0);
    tick(); tick();
    RST_n = 1'b1;
    tick();

    // Single frame, latency and pop
    avg_ready = 1'b1;
    pulse(17'd12800);
    chk("lat1_valid", 32'(avg_valid), 0);
    tick();
    chk("lat2_valid", 32'(avg_valid), 1);
    chk("f0_data", 32'(avg_data), 100);
    chk("f0_id", 32'(avg_frame_id), 0);
    chk("f0_count", 32'(fifo_count), 1);
    tick();
    chk("f0_popped", 32'(fifo_count), 0);

    // Rounding and saturation boundaries
    pulse(17'd12863); tick();
    chk("s12863", 32'(avg_data), 100);
    chk("s12863_id", 32'(avg_frame_id), 1);
    tick();
    pulse(17'd12864); tick();
`ifdef SUM_AVERAGE_ROUND_EN
    chk("s12864", 32'(avg_data), 101);
`else
    chk("s12864", 32'(avg_data), 100);
`endif
    tick();
    pulse(17'h1FFFF); tick();
    chk("sat", 32'(avg_data), 255);
    chk("sat_id", 32'(avg_frame_id), 3);
    tick();

    // Overflow: six frames into a stalled buffer
    do_clear();
    avg_ready = 1'b0;
    sum = 17'd1000; sum_enable = 1'b1;
    repeat (6) tick();
    sum_enable = 1'b0;
    tick(); tick();
    chk("ovf_count", 32'(fifo_count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    avg_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain_id", 32'(avg_frame_id), 32'(i));
      tick();
    end
    avg_ready = 1'b0;
    chk("ovf_empty", 32'(fifo_count), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    pulse(17'd1000); tick();
    chk("gap_id", 32'(avg_frame_id), 6);

    // Write and pop on the same edge while full
    do_clear();
    for (int i = 1; i <= 5; i++) pulse(17'(128 * 10 * i));
    chk("full_count", 32'(fifo_count), 4);
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
    chk("wp_count", 32'(fifo_count), 4);
    chk("wp_ovf", 32'(overflow), 0);
    chk("wp_head_id", 32'(avg_frame_id), 1);
    chk("wp_head_data", 32'(avg_data), 20);
    avg_ready = 1'b1;
    tick(); tick(); tick();
    chk("wp_tail_id", 32'(avg_frame_id), 4);
    chk("wp_tail_data", 32'(avg_data), 50);
    tick();
    avg_ready = 1'b0;

    // Clear beats a simultaneous sum_enable
    do_clear();
    pulse(17'd256); pulse(17'd512); pulse(17'd768);
    tick();
    chk("pre_clr_count", 32'(fifo_count), 3);
    sum_enable = 1'b1; clear = 1'b1;
    tick();
    sum_enable = 1'b0; clear = 1'b0;
    chk("clr_count", 32'(fifo_count), 0);
    chk("clr_valid", 32'(avg_valid), 0);
    chk("clr_ovf", 32'(overflow), 0);
    tick();
    chk("clr_discard", 32'(avg_valid), 0);
    pulse(17'd384); tick();
    chk("clr_next_id", 32'(avg_frame_id), 0);
    chk("clr_next_data", 32'(avg_data), 3);

    // Mixed traffic, checked by the reference every cycle
    for (int i = 0; i < 60; i++) begin
      sum = 17'($urandom_range(0, 17'h1FFFF));
      sum_enable = (i % 3 != 1);
      avg_ready = (i % 5 < 2);
      tick();
    end
    sum_enable = 1'b0;

    // Reset in the middle of traffic
    avg_ready = 1'b0;
    pulse(17'd1280);
    RST_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(avg_valid), 0);
    chk("mrst_count", 32'(fifo_count), 0);
    chk("mrst_ovf", 32'(overflow), 0);
    chk("mrst_data", 32'(avg_data), 0);
    tick();
    RST_n = 1'b1;
    tick();
    chk("mrst_inflight", 32'(avg_valid), 0);
    pulse(17'd2560); tick();
    chk("mrst_id", 32'(avg_frame_id), 0);
    chk("mrst_data2", 32'(avg_data), 20);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
